// File: rtl/ks_add_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined adder between two requesters.
// Define KS_SCHED_STALL_CNT_EN to build the saturating credit-stall counter on stall_cnt.
module ks_add_scheduler #(
  parameter int WIDTH = 24,
  parameter int LAT   = 6,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sign,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sign,
  output logic             add_valid,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sign,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_sign_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_sign,
  output logic             res_tag,
  output logic             busy,
  output logic [15:0]      stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(LAT + 2);
  localparam int UW = (((AW + 1) > IW) ? (AW + 1) : IW) + 1;
  localparam int EW = WIDTH + 3;

  logic             rr_ptr;
  logic             iss_valid;
  logic             iss_tag;
  logic [LAT-1:0]   trk_valid;
  logic [LAT-1:0]   trk_tag;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    head;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      fifo_count;
  logic [IW-1:0]    inflight;
  logic [UW-1:0]    used;
  logic             credit_ok;
  logic             grant0;
  logic             grant1;
  logic             grant;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;

  // Every accepted op holds one credit from its grant until it is popped from the FIFO.
  always_comb begin
    inflight = IW'(iss_valid);
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + IW'(trk_valid[i]);
    end
  end

  assign used      = UW'(fifo_count) + UW'(inflight);
  assign credit_ok = resetn && (used < UW'(DEPTH));

  assign grant0     = credit_ok && req0_valid && (!req1_valid || !rr_ptr);
  assign grant1     = credit_ok && req1_valid && (!req0_valid || rr_ptr);
  assign grant      = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rr_ptr    <= 1'b0;
      iss_valid <= 1'b0;
      iss_tag   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_sign  <= 1'b0;
    end else begin
      iss_valid <= grant;
      if (grant) begin
        add_a    <= grant1 ? req1_a : req0_a;
        add_b    <= grant1 ? req1_b : req0_b;
        add_sign <= grant1 ? req1_sign : req0_sign;
        iss_tag  <= grant1;
        rr_ptr   <= !grant1;
      end
    end
  end

  assign add_valid = iss_valid;

  // The last tracker slot lines up with the cycle the adder presents this op's sum.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      trk_valid <= '0;
      trk_tag   <= '0;
    end else begin
      trk_valid[0] <= iss_valid;
      trk_tag[0]   <= iss_tag;
      for (int i = 1; i < LAT; i++) begin
        trk_valid[i] <= trk_valid[i-1];
        trk_tag[i]   <= trk_tag[i-1];
      end
    end
  end

  assign push       = trk_valid[LAT-1];
  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (AW+1)'(DEPTH));
  assign pop        = res_ready && !fifo_empty;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {add_sum, add_cout, add_sign_o, trk_tag[LAT-1]};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign res_valid = !fifo_empty;
  assign head      = res_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign res_sum   = head[EW-1:3];
  assign res_cout  = head[2];
  assign res_sign  = head[1];
  assign res_tag   = head[0];
  assign busy      = (inflight != '0) || (fifo_count != '0);

  // The credit rule makes this unreachable; firing means credit accounting is broken.
  assert property (@(posedge clock) disable iff (!resetn) !(push && fifo_full));

`ifdef KS_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if ((req0_valid || req1_valid) && !credit_ok && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ks_add_scheduler.sv
// Scoreboard bench for ks_add_scheduler with a behavioural fixed-latency adder model.
module tb_ks_add_scheduler;

  localparam int WIDTH = 24;
  localparam int LAT   = 6;
  localparam int DEPTH = 8;

  typedef logic [WIDTH+2:0] res_t;

  logic             clock = 1'b0;
  logic             resetn;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_sign, req1_sign;
  logic             add_valid;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_sign, add_cout, add_sign_o;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout, res_sign, res_tag;
  logic             busy;
  logic [15:0]      stall_cnt;

  res_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [WIDTH:0] pipe_sum  [LAT];
  logic           pipe_sign [LAT];

  always #5 clock = ~clock;

  ks_add_scheduler #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sign(req0_sign),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sign(req1_sign),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_sign(add_sign),
    .add_sum(add_sum), .add_cout(add_cout), .add_sign_o(add_sign_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_sign(res_sign), .res_tag(res_tag), .busy(busy), .stall_cnt(stall_cnt)
  );

  // Adder model: fixed LAT-stage pipeline, no stall.
  always @(posedge clock) begin
    pipe_sum[0]  <= {1'b0, add_a} + {1'b0, add_b};
    pipe_sign[0] <= add_sign;
    for (int i = 1; i < LAT; i++) begin
      pipe_sum[i]  <= pipe_sum[i-1];
      pipe_sign[i] <= pipe_sign[i-1];
    end
  end

  assign add_sum    = pipe_sum[LAT-1][WIDTH-1:0];
  assign add_cout   = pipe_sum[LAT-1][WIDTH];
  assign add_sign_o = pipe_sign[LAT-1];

  function automatic res_t expect_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic s, input logic tag);
    logic [WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b};
    return {t[WIDTH-1:0], t[WIDTH], s, tag};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                               input logic s0, input logic v1, input logic [WIDTH-1:0] a1,
                               input logic [WIDTH-1:0] b1, input logic s1, input logic rr,
                               output logic g0, output logic g1);
    @(negedge clock);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sign = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sign = s1;
    res_ready  = rr;
    #1;
    g0 = v0 & req0_ready;
    g1 = v1 & req1_ready;
    if (g0) exp_q.push_back(expect_of(a0, b0, s0, 1'b0));
    if (g1) exp_q.push_back(expect_of(a1, b1, s1, 1'b1));
  endtask

  task automatic idle(input logic rr);
    logic d0, d1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, rr, d0, d1);
  endtask

  task automatic doReset();
    @(negedge clock);
    resetn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clock);
    exp_q.delete();
    resetn = 1'b1;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      idle(1'b1);
      n++;
    end
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops one expected result per accepted FIFO head.
  initial begin
    res_t e;
    forever begin
      @(negedge clock);
      #2;
      if (resetn === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_result: got %0h, expected none", {res_sum, res_cout, res_sign, res_tag});
        end else begin
          e = exp_q.pop_front();
          checkOutput("result", 32'({res_sum, res_cout, res_sign, res_tag}), 32'(e));
        end
      end
    end
  end

  initial begin
    logic g0, g1;
    int   grants, n;
    logic seen;

    resetn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_sign = 1'b0;
    req1_a = '0; req1_b = '0; req1_sign = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("rst_add_valid", 32'(add_valid), 32'd0);
    checkOutput("rst_add_a", 32'(add_a), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_sum", 32'(res_sum), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Single op: 1 + 1 with sign=1 from req0.
    applyStimulus(1'b1, 24'h000001, 24'h000001, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, g0, g1);
    checkOutput("t1_grant", 32'(g0), 32'd1);
    idle(1'b1);
    checkOutput("t1_add_valid", 32'(add_valid), 32'd1);
    checkOutput("t1_add_a", 32'(add_a), 32'h000001);
    checkOutput("t1_add_sign", 32'(add_sign), 32'd1);
    idle(1'b1);
    checkOutput("t1_add_pulse", 32'(add_valid), 32'd0);
    checkOutput("t1_add_a_hold", 32'(add_a), 32'h000001);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    for (int k = 3; k <= 7; k++) idle(1'b1);
    checkOutput("t1_res_early", 32'(res_valid), 32'd0);
    idle(1'b1);
    checkOutput("t1_res_valid", 32'(res_valid), 32'd1);
    checkOutput("t1_res_sum", 32'(res_sum), 32'd2);
    checkOutput("t1_res_cout", 32'(res_cout), 32'd0);
    checkOutput("t1_res_sign", 32'(res_sign), 32'd1);
    checkOutput("t1_res_tag", 32'(res_tag), 32'd0);
    waitDrain("t1");

    // Contention: both valid for 4 cycles -> grants 0,1,0,1.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 24'(10 + i), 24'h000001, 1'b0, 1'b1, 24'(32 + i), 24'h000003, 1'b1, 1'b1, g0, g1);
      checkOutput($sformatf("t2_grant0_%0d", i), 32'(g0), 32'((i % 2) == 0));
      checkOutput($sformatf("t2_grant1_%0d", i), 32'(g1), 32'((i % 2) == 1));
    end
    waitDrain("t2");

    // Back-pressure: res_ready=0 -> exactly DEPTH grants.
    doReset();
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 24'(i), 24'h000100, 1'(i), 1'b0, '0, '0, 1'b0, 1'b0, g0, g1);
      grants += int'(g0);
    end
    checkOutput("t3_grants", 32'(grants), 32'd8);
    applyStimulus(1'b1, 24'h000055, 24'h000100, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, g0, g1);
    checkOutput("t3_pop_cycle_ready", 32'(g0), 32'd0);
    checkOutput("t3_full_valid", 32'(res_valid), 32'd1);
`ifdef KS_SCHED_STALL_CNT_EN
    checkOutput("t3_stall_cnt4", 32'(stall_cnt), 32'd4);
`endif
    applyStimulus(1'b1, 24'h000055, 24'h000100, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, g0, g1);
    checkOutput("t3_regrant", 32'(g0), 32'd1);
    applyStimulus(1'b1, 24'h000066, 24'h000100, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, g0, g1);
    checkOutput("t3_denied_again", 32'(g0), 32'd0);
    idle(1'b0);
`ifdef KS_SCHED_STALL_CNT_EN
    checkOutput("t3_stall_cnt6", 32'(stall_cnt), 32'd6);
`endif
    waitDrain("t3");

    // Carry out plus 20 ops with random back-pressure across pointer wrap.
    doReset();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 24'hFFFFFF, 24'h000001, 1'b0, 1'b1, g0, g1);
    checkOutput("t4_carry_grant", 32'(g1), 32'd1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      idle(1'b1);
      seen = res_valid;
      n++;
    end
    checkOutput("t4_carry_seen", 32'(seen), 32'd1);
    checkOutput("t4_carry_sum", 32'(res_sum), 32'h000000);
    checkOutput("t4_carry_cout", 32'(res_cout), 32'd1);
    checkOutput("t4_carry_tag", 32'(res_tag), 32'd1);
    grants = 0;
    n = 0;
    while (grants < 20 && n < 400) begin
      applyStimulus(1'b1, 24'(n * 32'h01F3A7), 24'(32'hF00000 + n), 1'(n), 1'b1,
                    24'(n * 32'h0B0C0D + 32'h800000), 24'(32'hFFFF00 - n), 1'(n + 1),
                    1'($urandom_range(0, 1)), g0, g1);
      grants += int'(g0) + int'(g1);
      n++;
    end
    checkOutput("t4_grants", 32'(grants), 32'd20);
    waitDrain("t4");

    // Reset mid-flight: three ops dropped, nothing may ever be delivered.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 24'(i + 1), 24'h000010, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, g0, g1);
    end
    idle(1'b1);
    @(negedge clock);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checkOutput("t5_busy_after_reset", 32'(busy), 32'd0);
    checkOutput("t5_add_valid_after_reset", 32'(add_valid), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      idle(1'b1);
      seen = seen | res_valid;
    end
    checkOutput("t5_no_result", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
